// File: rtl/jtkunio_pcm_seq_pkg.sv
// Shared constants for the Kunio ADPCM sequencer: FSM encoding, ctrl register layout
// and the one-hot bank-select decode.
package jtkunio_pcm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } pcm_st_t;

    localparam int BYTE_W = 8;
    localparam int OKI_S  = 5;
    localparam int CE_HI  = 4;
    localparam int CE_LO  = 2;
    localparam int MSB_HI = 1;
    localparam int MSB_LO = 0;

    // Chip enables are one-hot; any illegal pattern falls back to bank 0
    function automatic logic [1:0] bank_dec(input logic [2:0] ce);
        case (ce)
            3'b001:  bank_dec = 2'd0;
            3'b010:  bank_dec = 2'd1;
            3'b100:  bank_dec = 2'd2;
            default: bank_dec = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtkunio_pcm_fetch.sv
// PCM ROM fetch engine: two-slot prefetch buffer (CUR/NXT), byte counter and
// the cs/ok handshake with a one-cycle address-settle guard.
module jtkunio_pcm_fetch
    import jtkunio_pcm_seq_pkg::*;
#(
    parameter int CNTW = 14,
    parameter int AW   = 17
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              pop,
    input  logic [1:0]        bank,
    input  logic [1:0]        msb,
    output logic [AW-1:0]     pcm_addr,
    output logic              pcm_cs,
    input  logic [BYTE_W-1:0] pcm_data,
    input  logic              pcm_ok,
    output logic [BYTE_W-1:0] cur,
    output logic              cur_v
);

    logic [BYTE_W-1:0] nxt;
    logic              nxt_v;
    logic [CNTW-1:0]   fcnt;
    logic              settle;
    logic              want;
    logic [BYTE_W-1:0] cur_a;
    logic              cur_va;
    logic              nxt_va;

    // fcnt carries one bit beyond the byte address so the end of the sample is visible
    assign want = en && !(cur_v && nxt_v) && !fcnt[CNTW-1];

    always_comb begin
        cur_a  = cur;
        cur_va = cur_v;
        nxt_va = nxt_v;
        if (pop) begin
            cur_a  = nxt;
            cur_va = nxt_v;
            nxt_va = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            cur_v    <= 1'b0;
            nxt      <= '0;
            nxt_v    <= 1'b0;
            fcnt     <= '0;
            settle   <= 1'b0;
            pcm_cs   <= 1'b0;
            pcm_addr <= '0;
        end else if (start || stop) begin
            // Anything in flight is abandoned; a start immediately requests byte 0
            cur_v  <= 1'b0;
            nxt_v  <= 1'b0;
            fcnt   <= '0;
            settle <= start;
            pcm_cs <= start;
            if (start)
                pcm_addr <= {bank, msb, {(CNTW-1){1'b0}}};
        end else begin
            cur    <= cur_a;
            cur_v  <= cur_va;
            nxt_v  <= nxt_va;
            settle <= 1'b0;
            if (pcm_cs) begin
                if (!en) begin
                    pcm_cs <= 1'b0;
                end else if (!settle && pcm_ok) begin
                    pcm_cs <= 1'b0;
                    fcnt   <= fcnt + 1'b1;
                    if (!cur_va) begin
                        cur   <= pcm_data;
                        cur_v <= 1'b1;
                    end else begin
                        nxt   <= pcm_data;
                        nxt_v <= 1'b1;
                    end
                end
            end else if (want) begin
                pcm_cs   <= 1'b1;
                pcm_addr <= {bank, msb, fcnt[CNTW-2:0]};
                settle   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtkunio_pcm_seq.sv
// ADPCM sample sequencer: sound-CPU start/stop/ctrl handling, playback FSM,
// nibble mux to the jt5205 and end-of-sample NMI.
module jtkunio_pcm_seq
    import jtkunio_pcm_seq_pkg::*;
#(
    parameter int CNTW = 14,
    parameter int AW   = 17
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_we,
    input  logic [5:0]    ctrl_din,
    input  logic          start_we,
    input  logic          stop_we,
    input  logic          vclk,
    output logic [AW-1:0] pcm_addr,
    output logic          pcm_cs,
    input  logic [7:0]    pcm_data,
    input  logic          pcm_ok,
    output logic [3:0]    dec_din,
    output logic [1:0]    dec_sel,
    output logic          dec_rst,
    output logic          nmi_n,
    output logic          underrun
);

    pcm_st_t           st;
    logic [5:0]        ctrl;
    logic [CNTW-1:0]   pcnt;
    logic [BYTE_W-1:0] cur;
    logic              cur_v;
    logic              play;
    logic              pop;
    logic [1:0]        bank;
    logic [1:0]        msb;

    assign play    = (st == ST_PLAY);
    assign pop     = play && vclk && cur_v && pcnt[0];
    assign bank    = bank_dec(ctrl[CE_HI:CE_LO]);
    assign msb     = ctrl[MSB_HI:MSB_LO];
    assign dec_sel = {1'b0, ctrl[OKI_S]};

    // Low nibble first; silence whenever the current byte is not there yet
    always_comb begin
        dec_din = 4'd0;
        if (cur_v)
            dec_din = pcnt[0] ? cur[7:4] : cur[3:0];
    end

    jtkunio_pcm_fetch #(
        .CNTW (CNTW),
        .AW   (AW)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .en       (play),
        .start    (start_we),
        .stop     (stop_we),
        .pop      (pop),
        .bank     (bank),
        .msb      (msb),
        .pcm_addr (pcm_addr),
        .pcm_cs   (pcm_cs),
        .pcm_data (pcm_data),
        .pcm_ok   (pcm_ok),
        .cur      (cur),
        .cur_v    (cur_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            ctrl     <= '0;
            pcnt     <= '0;
            nmi_n    <= 1'b1;
            dec_rst  <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (ctrl_we)
                ctrl <= ctrl_din;
            // start outranks stop, vclk and the terminal count
            if (start_we) begin
                pcnt    <= '0;
                nmi_n   <= 1'b1;
                dec_rst <= 1'b0;
                st      <= ST_PLAY;
            end else if (stop_we) begin
                nmi_n   <= 1'b1;
                dec_rst <= 1'b1;
                st      <= ST_IDLE;
            end else begin
                case (st)
                    ST_IDLE: dec_rst <= 1'b1;
                    ST_PLAY: begin
                        if (vclk) begin
                            if (!cur_v)
                                underrun <= 1'b1;
                            else if (&pcnt)
                                st <= ST_DONE;
                            else
                                pcnt <= pcnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        nmi_n   <= 1'b0;
                        dec_rst <= 1'b1;
                        st      <= ST_IDLE;
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtkunio_pcm_seq.sv
// Directed bench: a full-size sequencer and a 3-bit-counter one share the CPU-side
// stimulus, each with its own ROM model answering 3 cycles after a stable request.
module tb_jtkunio_pcm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_we = 1'b0;
    logic [5:0]  ctrl_din = '0;
    logic        start_we = 1'b0;
    logic        stop_we = 1'b0;
    logic        vclk = 1'b0;
    logic        hold_ok = 1'b0;

    logic [16:0] pcm_addr;
    logic        pcm_cs;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic [3:0]  dec_din;
    logic [1:0]  dec_sel;
    logic        dec_rst;
    logic        nmi_n;
    logic        underrun;

    logic [5:0]  s_addr;
    logic        s_cs;
    logic [7:0]  s_data;
    logic        s_ok;
    logic [3:0]  s_din;
    logic [1:0]  s_sel;
    logic        s_drst;
    logic        s_nmi_n;
    logic        s_under;

    int total = 0;
    int bad = 0;
    int m_cnt = 0;
    int s_cnt = 0;
    logic [16:0] m_last = '0;
    logic [5:0]  s_last = '0;

    always #5 clk = ~clk;

    jtkunio_pcm_seq #(.CNTW(14), .AW(17)) dut (
        .clk(clk), .rst(rst), .ctrl_we(ctrl_we), .ctrl_din(ctrl_din),
        .start_we(start_we), .stop_we(stop_we), .vclk(vclk),
        .pcm_addr(pcm_addr), .pcm_cs(pcm_cs), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .dec_din(dec_din), .dec_sel(dec_sel), .dec_rst(dec_rst),
        .nmi_n(nmi_n), .underrun(underrun)
    );

    jtkunio_pcm_seq #(.CNTW(3), .AW(6)) dut_s (
        .clk(clk), .rst(rst), .ctrl_we(ctrl_we), .ctrl_din(ctrl_din),
        .start_we(start_we), .stop_we(stop_we), .vclk(vclk),
        .pcm_addr(s_addr), .pcm_cs(s_cs), .pcm_data(s_data), .pcm_ok(s_ok),
        .dec_din(s_din), .dec_sel(s_sel), .dec_rst(s_drst),
        .nmi_n(s_nmi_n), .underrun(s_under)
    );

    // ROM byte at address a: high nibble = a[3:0]+7, low nibble = a[3:0]+3
    function automatic logic [7:0] rom_byte(input logic [3:0] a);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = a + 4'd7;
        lo = a + 4'd3;
        return {hi, lo};
    endfunction

    always @(posedge clk) begin
        if (pcm_cs && pcm_addr == m_last) m_cnt <= m_cnt + 1;
        else m_cnt <= 0;
        m_last <= pcm_addr;
        if (s_cs && s_addr == s_last) s_cnt <= s_cnt + 1;
        else s_cnt <= 0;
        s_last <= s_addr;
    end

    assign pcm_ok   = pcm_cs && (m_cnt >= 3) && !hold_ok;
    assign pcm_data = rom_byte(pcm_addr[3:0]);
    assign s_ok     = s_cs && (s_cnt >= 3) && !hold_ok;
    assign s_data   = rom_byte(s_addr[3:0]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ctrl(input logic [5:0] v);
        ctrl_din = v;
        ctrl_we = 1'b1;
        step(1);
        ctrl_we = 1'b0;
    endtask

    task automatic pulse_start();
        start_we = 1'b1;
        step(1);
        start_we = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_we = 1'b1;
        step(1);
        stop_we = 1'b0;
    endtask

    task automatic pulse_vclk();
        vclk = 1'b1;
        step(1);
        vclk = 1'b0;
    endtask

    task automatic wait_cs(input logic lvl, input int lim, input string tag);
        int n;
        n = 0;
        while (pcm_cs !== lvl && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, pcm_cs, lvl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_addr", pcm_addr, 17'h0);
        chk("rst_cs", pcm_cs, 1'b0);
        chk("rst_nmi", nmi_n, 1'b1);
        chk("rst_decrst", dec_rst, 1'b1);
        chk("rst_din", dec_din, 4'h0);
        chk("rst_under", underrun, 1'b0);
        chk("rst_sel", dec_sel, 2'b00);
        chk("rst_s_nmi", s_nmi_n, 1'b1);
        rst = 1'b0;
        step(1);

        // 1: bank 1, msb 3 -> {01,11,0...}
        pulse_ctrl(6'b0_010_11);
        pulse_start();
        chk("t1_cs_first", pcm_cs, 1'b1);
        chk("t1_addr0", pcm_addr, 17'h0E000);
        chk("t1_decrst", dec_rst, 1'b0);
        chk("t1_din_empty", dec_din, 4'h0);
        wait_cs(1'b0, 20, "t1_cap0");
        chk("t1_lo0", dec_din, 4'h3);
        pulse_vclk();
        chk("t1_hi0", dec_din, 4'h7);
        wait_cs(1'b1, 10, "t1_req1");
        chk("t1_addr1", pcm_addr, 17'h0E001);
        wait_cs(1'b0, 20, "t1_cap1");
        pulse_vclk();
        chk("t1_lo1", dec_din, 4'h4);
        pulse_vclk();
        chk("t1_hi1", dec_din, 4'h8);

        // 2: small sequencer, 8 nibbles to the NMI
        pulse_ctrl(6'b0_001_00);
        pulse_start();
        step(20);
        for (int i = 0; i < 8; i++) begin
            pulse_vclk();
            if (i == 6) chk("t2_s_hi3", s_din, 4'hA);
            if (i < 7) step(15);
        end
        chk("t2_nmi_d1", s_nmi_n, 1'b1);
        step(1);
        chk("t2_nmi_d2", s_nmi_n, 1'b0);
        chk("t2_decrst", s_drst, 1'b1);
        step(10);
        chk("t2_nmi_held", s_nmi_n, 1'b0);
        pulse_stop();
        chk("t2_nmi_ack", s_nmi_n, 1'b1);

        // 3: ROM stalls, underruns, then resume at nibble 0
        hold_ok = 1'b1;
        pulse_start();
        step(10);
        for (int i = 0; i < 3; i++) begin
            pulse_vclk();
            chk("t3_under", underrun, 1'b1);
            chk("t3_din0", dec_din, 4'h0);
            step(1);
            chk("t3_under_end", underrun, 1'b0);
            step(62);
        end
        hold_ok = 1'b0;
        step(20);
        chk("t3_resume_lo", dec_din, 4'h3);
        pulse_vclk();
        chk("t3_resume_hi", dec_din, 4'h7);

        // 4: restart at pcnt=5 with byte 3 in flight
        pulse_start();
        step(20);
        for (int i = 0; i < 3; i++) begin
            pulse_vclk();
            step(15);
        end
        hold_ok = 1'b1;
        pulse_vclk();
        step(5);
        pulse_vclk();
        chk("t4_hi2", dec_din, 4'h9);
        chk("t4_inflight", pcm_cs, 1'b1);
        chk("t4_addr3", pcm_addr, 17'h00003);
        pulse_start();
        chk("t4_addr_rst", pcm_addr, 17'h00000);
        chk("t4_din_drop", dec_din, 4'h0);
        chk("t4_nmi", nmi_n, 1'b1);
        hold_ok = 1'b0;
        step(20);
        chk("t4_fresh_lo", dec_din, 4'h3);

        // 5: start beats stop; start beats the terminal vclk
        start_we = 1'b1;
        stop_we = 1'b1;
        step(1);
        start_we = 1'b0;
        stop_we = 1'b0;
        chk("t5_play_decrst", dec_rst, 1'b0);
        chk("t5_play_cs", pcm_cs, 1'b1);
        step(20);
        for (int i = 0; i < 7; i++) begin
            pulse_vclk();
            step(15);
        end
        vclk = 1'b1;
        start_we = 1'b1;
        step(1);
        vclk = 1'b0;
        start_we = 1'b0;
        chk("t5_s_decrst", s_drst, 1'b0);
        chk("t5_s_din", s_din, 4'h0);
        step(3);
        chk("t5_s_nonmi", s_nmi_n, 1'b1);

        // 6: illegal ce -> bank 0; msb change applies to the next fetch
        pulse_ctrl(6'b1_011_10);
        pulse_start();
        chk("t6_addr_b0", pcm_addr, 17'h04000);
        chk("t6_sel", dec_sel, 2'b01);
        step(20);
        pulse_ctrl(6'b1_011_01);
        chk("t6_addr_hold", pcm_addr, 17'h04001);
        pulse_vclk();
        step(2);
        pulse_vclk();
        wait_cs(1'b1, 10, "t6_req2");
        chk("t6_addr_newmsb", pcm_addr, 17'h02002);
        pulse_ctrl(6'b0_100_00);
        pulse_start();
        chk("t6_addr_b2", pcm_addr, 17'h10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
